// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and address decode for the LSU data-memory responder
package dmem_pkg;

   typedef logic [63:0] word_t;
   typedef logic [63:0] addr_t;

   localparam int WORD_BYTES = 8;

   typedef struct packed {
      addr_t index;
      logic  in_range;
      logic  misaligned;
   } dec_t;

   // Word index is the full offset shifted down; callers keep only the bits their depth needs.
   function automatic dec_t addr_decode(input addr_t addr, input addr_t base, input int depth);
      dec_t  d;
      addr_t offset;
      offset       = addr - base;
      d.index      = offset >> 3;
      d.in_range   = offset < (addr_t'(depth) << 3);
      d.misaligned = addr[2:0] != 3'b000;
      return d;
   endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: fixed-latency read response pipeline, pure wires at latency 0
module dmem_rd_pipe
   import dmem_pkg::*;
#(
   parameter int READ_LATENCY = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  in_valid,
   input  word_t in_data,
   output logic  out_valid,
   output word_t out_data
);

   if (READ_LATENCY == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_data       = in_valid ? in_data : '0;
   end else begin : g_pipe
      logic  vld [READ_LATENCY];
      word_t dat [READ_LATENCY];
      // shift valid/data; empty slots carry zero so the output data is zero whenever valid is low
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
               vld[i] <= 1'b0;
               dat[i] <= '0;
            end
         end else begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
               vld[i] <= vld[i-1];
               dat[i] <= dat[i-1];
            end
         end
      end
      assign out_valid = vld[READ_LATENCY-1];
      assign out_data  = dat[READ_LATENCY-1];
   end

endmodule

// File: rtl/lsu_dmem_responder.sv
// lsu_dmem_responder: word-addressed data memory serving one LSU port, with error flags and traffic counters
module lsu_dmem_responder
   import dmem_pkg::*;
#(
   parameter int    DEPTH_WORDS  = 1024,
   parameter int    READ_LATENCY = 0,
   parameter addr_t BASE_ADDR    = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren,
   input  logic [63:0] mem_raddr,
   output logic        mem_rvalid,
   output logic [63:0] mem_rdata,
   input  logic        mem_wen,
   input  logic [63:0] mem_waddr,
   input  logic [63:0] mem_wdata,
   input  logic        dbg_we,
   input  logic [63:0] dbg_addr,
   input  logic [63:0] dbg_wdata,
   output logic        err_misaligned,
   output logic        err_range,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int IW = $clog2(DEPTH_WORDS);

   word_t mem [DEPTH_WORDS];
   dec_t  rd_dec, wr_dec, dbg_dec;
   logic  rd_req, wr_req;
   word_t rd_word;
   logic  unused_bits;

   assign rd_dec  = addr_decode(mem_raddr, BASE_ADDR, DEPTH_WORDS);
   assign wr_dec  = addr_decode(mem_waddr, BASE_ADDR, DEPTH_WORDS);
   assign dbg_dec = addr_decode(dbg_addr, BASE_ADDR, DEPTH_WORDS);
   assign rd_req  = mem_ren & ~rst;
   assign wr_req  = mem_wen & ~rst;
   assign rd_word = rd_dec.in_range ? mem[rd_dec.index[IW-1:0]] : '0;
   assign unused_bits = ^{rd_dec.index[63:IW], wr_dec.index[63:IW], dbg_dec.index[63:IW], dbg_dec.misaligned};

   // backdoor first, LSU write second, so the LSU wins an index collision; reads see pre-edge contents
   always_ff @(posedge clk) begin
      if (dbg_we && dbg_dec.in_range) mem[dbg_dec.index[IW-1:0]] <= dbg_wdata;
      if (wr_req && wr_dec.in_range) mem[wr_dec.index[IW-1:0]] <= mem_wdata;
   end

   // sticky error flags and wrapping traffic counters, LSU port only
   always_ff @(posedge clk) begin
      if (rst) begin
         err_misaligned <= 1'b0;
         err_range      <= 1'b0;
         rd_count       <= '0;
         wr_count       <= '0;
      end else begin
         if ((mem_ren && rd_dec.misaligned) || (mem_wen && wr_dec.misaligned)) err_misaligned <= 1'b1;
         if ((mem_ren && !rd_dec.in_range) || (mem_wen && !wr_dec.in_range)) err_range <= 1'b1;
         if (mem_ren) rd_count <= rd_count + 32'd1;
         if (mem_wen) wr_count <= wr_count + 32'd1;
      end
   end

   dmem_rd_pipe #(.READ_LATENCY(READ_LATENCY)) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_req),
      .in_data   (rd_word),
      .out_valid (mem_rvalid),
      .out_data  (mem_rdata)
   );

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// tb_lsu_dmem_responder: three latencies driven in lockstep, scoreboarded read responses plus directed flag/counter checks
module tb_lsu_dmem_responder;
   import dmem_pkg::*;

   typedef struct {
      word_t data;
      int    due;
   } exp_t;

   logic        clk, rst, rst3x;
   logic        ren, wen, dbg_we;
   addr_t       raddr, waddr, dbg_addr;
   word_t       wdata, dbg_wdata;
   logic        rv [3];
   word_t       rdv [3];
   logic        em [3], er [3];
   logic [31:0] rc [3], wc [3];

   int    checks = 0, errors = 0, cyc = 0;
   int    exp_rc = 0, exp_wc = 0;
   int    lat [3] = '{0, 2, 3};
   logic  no3 = 1'b0;
   exp_t  q [3][$];
   word_t model [int];

   lsu_dmem_responder #(.READ_LATENCY(0)) u_l0 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_raddr(raddr), .mem_rvalid(rv[0]), .mem_rdata(rdv[0]),
      .mem_wen(wen), .mem_waddr(waddr), .mem_wdata(wdata), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .err_misaligned(em[0]), .err_range(er[0]), .rd_count(rc[0]), .wr_count(wc[0]));
   lsu_dmem_responder #(.READ_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .mem_ren(ren), .mem_raddr(raddr), .mem_rvalid(rv[1]), .mem_rdata(rdv[1]),
      .mem_wen(wen), .mem_waddr(waddr), .mem_wdata(wdata), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .err_misaligned(em[1]), .err_range(er[1]), .rd_count(rc[1]), .wr_count(wc[1]));
   lsu_dmem_responder #(.READ_LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst | rst3x), .mem_ren(ren), .mem_raddr(raddr), .mem_rvalid(rv[2]), .mem_rdata(rdv[2]),
      .mem_wen(wen), .mem_waddr(waddr), .mem_wdata(wdata), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .err_misaligned(em[2]), .err_range(er[2]), .rd_count(rc[2]), .wr_count(wc[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // response monitor: pop when due, otherwise rvalid and rdata must both be low
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (q[i].size() != 0 && q[i][0].due <= cyc) begin
            e = q[i].pop_front();
            assert (rv[i] === 1'b1 && rdv[i] === e.data && e.due == cyc) else begin
               errors++;
               $error("FAIL rsp_l%0d cyc %0d: observed rvalid=%b rdata=%h, expected rvalid=1 rdata=%h due %0d",
                      lat[i], cyc, rv[i], rdv[i], e.data, e.due);
            end
         end else begin
            assert (rv[i] === 1'b0 && rdv[i] === 64'h0) else begin
               errors++;
               $error("FAIL idle_l%0d cyc %0d: observed rvalid=%b rdata=%h, expected rvalid=0 rdata=0",
                      lat[i], cyc, rv[i], rdv[i]);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      ren = 1'b0;
      wen = 1'b0;
      dbg_we = 1'b0;
   endtask

   task automatic rd(input addr_t a);
      word_t e;
      e = (a < 64'h2000) ? model[int'(a >> 3)] : '0;
      ren = 1'b1;
      raddr = a;
      exp_rc++;
      for (int i = 0; i < 3; i++)
         if (i != 2 || !no3) q[i].push_back('{data: e, due: cyc + lat[i]});
   endtask

   task automatic wr(input addr_t a, input word_t d);
      wen = 1'b1;
      waddr = a;
      wdata = d;
      exp_wc++;
      if (a < 64'h2000) model[int'(a >> 3)] = d;
   endtask

   task automatic dbg(input addr_t a, input word_t d);
      dbg_we = 1'b1;
      dbg_addr = a;
      dbg_wdata = d;
      if (a < 64'h2000) model[int'(a >> 3)] = d;
   endtask

   initial begin
      rst = 1'b1; rst3x = 1'b0;
      ren = 1'b0; wen = 1'b0; dbg_we = 1'b0;
      raddr = '0; waddr = '0; wdata = '0; dbg_addr = '0; dbg_wdata = '0;
      next();
      ren = 1'b1;
      raddr = 64'h0;
      @(negedge clk);
      check("rst_rvalid_l0", 64'(rv[0]), 64'h0);
      next();
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_rd_count_l%0d", lat[i]), 64'(rc[i]), 64'h0);
         check($sformatf("rst_flags_l%0d", lat[i]), 64'({em[i], er[i]}), 64'h0);
      end
      next(); dbg(64'h40, 64'hDEAD_BEEF);
      next(); dbg(64'h0, 64'd1);
      next(); dbg(64'h8, 64'd2);
      next(); dbg(64'h10, 64'd3);
      next(); dbg(64'h18, 64'd5);
      next(); rd(64'h40);
      next();
      @(negedge clk);
      check("rd_count_first", 64'(rc[0]), 64'(exp_rc));
      check("wr_count_dbg_uncounted", 64'(wc[0]), 64'h0);
      next(); rd(64'h0);
      next(); rd(64'h8);
      next(); rd(64'h10);
      next(); rd(64'h18); wr(64'h18, 64'd7);
      next(); rd(64'h18);
      next();
      @(negedge clk);
      check("wr_count_one", 64'(wc[0]), 64'd1);
      check("rd_count_six", 64'(rc[0]), 64'(exp_rc));
      check("flags_clean", 64'({em[0], er[0]}), 64'h0);
      next(); dbg(64'h3000, 64'd9);
      next(); dbg(64'h49, 64'h99);
      next();
      @(negedge clk);
      check("dbg_no_flags", 64'({em[0], er[0]}), 64'h0);
      next(); rd(64'h43);
      next();
      @(negedge clk);
      check("misaligned_set", 64'(em[0]), 64'h1);
      check("range_still_clear", 64'(er[0]), 64'h0);
      next(); rd(64'h2004);
      next(); wr(64'h2000, 64'hBAD);
      next();
      @(negedge clk);
      check("range_set", 64'(er[1]), 64'h1);
      next();
      next();
      @(negedge clk);
      check("range_sticky", 64'(er[0]), 64'h1);
      check("misaligned_sticky", 64'(em[2]), 64'h1);
      next(); rd(64'h0);
      next(); rd(64'h48);
      next(); dbg(64'h20, 64'hBB); wr(64'h20, 64'hAA);
      next(); rd(64'h20);
      next();
      @(negedge clk);
      check("rd_count_mid", 64'(rc[1]), 64'(exp_rc));
      check("wr_count_mid", 64'(wc[1]), 64'(exp_wc));
      repeat (4) next();
      no3 = 1'b1;
      rd(64'h10);
      next();
      rst3x = 1'b1;
      next();
      rst3x = 1'b0;
      no3 = 1'b0;
      @(negedge clk);
      check("l3_rst_rd_count", 64'(rc[2]), 64'h0);
      check("l3_rst_wr_count", 64'(wc[2]), 64'h0);
      check("l3_rst_flags", 64'({em[2], er[2]}), 64'h0);
      check("l0_count_kept", 64'(rc[0]), 64'(exp_rc));
      next(); rd(64'h40);
      next();
      force u_l0.wr_count = 32'hFFFF_FFFF;
      #1;
      release u_l0.wr_count;
      next(); wr(64'h28, 64'd1);
      next(); wr(64'h28, 64'd2);
      next();
      @(negedge clk);
      check("wr_count_wrap", 64'(wc[0]), 64'd1);
      next(); rd(64'h28);
      repeat (6) next();
      for (int i = 0; i < 3; i++) check($sformatf("drained_l%0d", lat[i]), 64'(q[i].size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_dmem_responder.md
Name: lsu_dmem_responder

Overview:
- Data-memory responder for the load/store FU memory port; it is the slave that serves mem_ren/mem_wen requests.
- Holds a word-addressed 64-bit array and returns read data with a configurable, fixed latency.
- Flags misaligned and out-of-range accesses and counts traffic for perf/debug.
- Sits between fu_lsu and the top-level/testbench memory; one instance per LSU port.

Parameters:
DEPTH_WORDS, 1024, number of 64-bit words; power of two, >= 2
READ_LATENCY, 0, cycles from request to mem_rvalid; 0 = combinational (the mode the current LSU needs); legal range 0..4
BASE_ADDR, 64'h0, byte address of word 0

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
mem_ren  input  1  read request; each cycle high is one request
mem_raddr  input  64  byte read address
mem_rvalid  output  1  read data valid
mem_rdata  output  64  read data
mem_wen  input  1  write request; each cycle high is one write
mem_waddr  input  64  byte write address
mem_wdata  input  64  write data
dbg_we  input  1  backdoor preload write
dbg_addr  input  64  backdoor byte address
dbg_wdata  input  64  backdoor data
err_misaligned  output  1  sticky: any access with addr[2:0] != 0
err_range  output  1  sticky: any access outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS)
rd_count  output  32  accepted read requests, wraps at 2^32
wr_count  output  32  accepted mem_wen writes, wraps at 2^32

Behaviour:
- Reset:
  - mem_rvalid=0, mem_rdata=0, err flags=0, counters=0.
  - All in-flight reads are dropped; array contents are not cleared.
  - A request arriving in the reset cycle is ignored and not counted.
- Address decode:
  - offset = addr - BASE_ADDR (64-bit wrap).
  - index = offset[log2(DEPTH_WORDS)+2:3].
  - In range iff offset < 8*DEPTH_WORDS.
  - Misaligned accesses use the truncated index (addr[2:0] ignored) and set err_misaligned.
- Reads:
  - In-range read returns array[index]; out-of-range read returns 64'h0 with rvalid still asserted, and sets err_range.
  - READ_LATENCY=0:
    - mem_rvalid = mem_ren & ~rst, combinational.
    - mem_rdata = array value at the start of the cycle; zero when mem_rvalid=0.
  - READ_LATENCY=N>=1:
    - Request sampled at edge k produces rvalid/rdata during the cycle after edge k+N-1, i.e. N cycles later.
    - Shift pipeline of depth N; back-to-back requests give back-to-back responses, in order, no stalls.
    - mem_rdata=0 whenever mem_rvalid=0.
- Writes:
  - mem_wen in range writes array[index] at the clock edge. Out-of-range writes are dropped and set err_range.
  - dbg_we writes the same way but is not counted and does not set the error flags.
  - Same cycle, same index for mem_wen and dbg_we: mem_wen wins.
- Read/write ordering:
  - Read and write to the same index in the same cycle: the read returns the OLD value, at every latency.
  - A read one cycle after a write sees the new value.
- Counters: rd_count increments per cycle with mem_ren=1; wr_count per cycle with mem_wen=1. This includes erroneous accesses; both can increment in the same cycle.
- No backpressure: the responder always accepts. An LSU holding mem_ren high for k cycles gets k responses.

Decomposition:
- Package dmem_pkg:
  - word_t (logic [63:0]).
  - addr_t.
  - WORD_BYTES=8.
  - function addr_decode(addr, base, depth) returning {index, in_range, misaligned}.
- Sub-module dmem_rd_pipe:
  - Parameterised READ_LATENCY valid/data shift register with synchronous clear.
  - Bypassed (pure wires) when READ_LATENCY=0.

Test Plan:
- Preload via dbg_we addr 0x40=64'hDEAD_BEEF; READ_LATENCY=0; mem_ren with raddr 0x40 -> same cycle mem_rvalid=1, mem_rdata=64'hDEAD_BEEF, rd_count=1.
- READ_LATENCY=2; mem_ren for 3 consecutive cycles at 0x0, 0x8, 0x10 preloaded with 1, 2, 3 -> rvalid high for 3 cycles starting 2 cycles after the first request, data 1, 2, 3 in order.
- Same cycle: mem_wen waddr 0x18 wdata 7 and mem_ren raddr 0x18 (old value 5) -> rdata=5; read next cycle -> 7; wr_count=1.
- mem_ren raddr 0x2004 with DEPTH_WORDS=1024 -> rvalid=1, rdata=0, err_range=1 and err_misaligned=1, both staying set; mem_wen to 0x2000 -> array unchanged.
- READ_LATENCY=3; issue a read, assert rst one cycle later -> no rvalid ever appears; counters and flags read 0 after reset; preloaded contents remain readable.
- Drive mem_wen for 2^32+1 cycles in a forced-counter test -> wr_count wraps to 1.
